ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised iterative RV32M multiply/divide unit used by the execute stage for op_reg instructions with funct7[0]=1.
- Replaces the single-mode ALU multiply path with a valid/ready request/response handshake, per-op latency and pipeline flush support.
- Adds a reuse cache that returns a DIV→REM or MUL→MULH pair in 1 cycle when both instructions use the same operands.
- The execute stage holds mul_stall high from request until the response is consumed.

Parameters:
- XLEN, 32: operand/result width; must be even.
- MUL_BITS, 2: multiplier bits retired per cycle; must divide XLEN; legal values 1, 2, 4.
- TAG_W, 6: width of the opaque request tag (instruction order low bits).
- REUSE_EN, 1: enables the last-result reuse cache.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the in-flight operation; no response is produced
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_funct3  in  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- req_a  in  XLEN  rs1 operand (already forwarded)
- req_b  in  XLEN  rs2 operand (already forwarded)
- req_tag  in  TAG_W  returned unchanged with the response
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes the result
- resp_result  out  XLEN  result
- resp_tag  out  TAG_W  tag of the completed request
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, DIV, DONE. req_ready = (state==IDLE) & ~flush.
- Reset:
  - state=IDLE, counter=0, reuse-cache valid=0.
  - resp_valid=0, resp_result=0, resp_tag=0, busy=0.
  - Reset mid-operation abandons the operation; no response is produced.
- Accept: on an edge with req_valid & req_ready, latch funct3, tag, operand magnitudes and sign flags, then pick the path by priority:
  - Reuse hit (REUSE_EN=1, cache valid, same a, same b, same signedness class) → DONE; resp_valid in the next cycle (latency 1).
  - Divide by zero (b=0, funct3≥4) → DONE, latency 1. DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (DIV/REM, a=100…0, b=all ones) → DONE, latency 1. DIV result = a; REM result = 0.
  - Otherwise MUL (funct3<4) or DIV.
- Signedness classes:
  - {MUL, MULH}: signed × signed.
  - MULHSU: signed × unsigned.
  - MULHU: unsigned × unsigned.
  - {DIV, REM}: signed.
  - {DIVU, REMU}: unsigned.
- MUL state:
  - Shift-add on magnitudes into a 2·XLEN accumulator, MUL_BITS per cycle, for XLEN/MUL_BITS cycles.
  - Then negate if the sign flags differ, and go to DONE.
  - Latency from accept edge to resp_valid: XLEN/MUL_BITS+1 (17 at defaults).
  - Result: MUL = low XLEN bits; MULH* = high XLEN bits.
- DIV state:
  - Restoring divide on magnitudes, 1 bit/cycle, for XLEN cycles. Latency XLEN+1 (33).
  - Quotient negated if the sign flags differ; remainder takes the sign of the dividend.
- Cache update: on the normal completion path, store a, b, signedness class, the full product or quotient+remainder, and set valid=1. Hit and special-case paths do not write the cache.
- DONE state:
  - resp_valid=1; resp_result and resp_tag are held stable while resp_ready=0.
  - On resp_valid & resp_ready → IDLE. No back-to-back accept in that same cycle, because req_ready=0 in DONE.
- Flush:
  - Any state → IDLE on the next edge; resp_valid drops on that edge.
  - Flush beats accept in the same cycle.
  - Cache contents stay valid, since they depend only on operands.
- The counter wraps only via the explicit reload on accept; it never free-runs.

Decomposition:
- In package types:
  - muldiv_op_t enum for funct3 values.
  - muldiv_state_t enum.
  - Signedness-class enum.
  - Localparams MUL_CYCLES = XLEN/MUL_BITS and DIV_CYCLES = XLEN.
- One natural sub-module: muldiv_div_step, a combinational single restoring-divide iteration (remainder, quotient, divisor → next remainder, quotient). Multiply stays inline.

Test Plan:
- Test 1, MUL a=7, b=-3, MUL_BITS=2:
  - resp_valid first high exactly 17 cycles after the accept edge, result=0xFFFFFFEB.
  - Then MULH with the same operands → resp in 1 cycle, result=0xFFFFFFFF.
- Test 2, DIV a=-20, b=6: after 33 cycles result=0xFFFFFFFD. Then REM with the same operands → 1 cycle, result=0xFFFFFFFE.
- Test 3, DIVU a=5, b=0 → 1 cycle, result=0xFFFFFFFF. REMU a=5, b=0 → result=5.
- Test 4, DIV a=0x80000000, b=0xFFFFFFFF → result=0x80000000. REM with the same operands → result=0.
- Test 5, MULHU a=b=0xFFFFFFFF with resp_ready held low 5 cycles: result=0xFFFFFFFE and tag stay stable; IDLE one cycle after resp_ready rises.
- Test 6, flush at cycle 10 of a DIV:
  - No resp_valid; busy=0 next cycle.
  - A simultaneous req_valid is not accepted.
  - A new MUL issued afterwards completes with its own tag.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Holds the opcode, state and signedness-class enums plus the default step counts.
// Pure declarations; no logic lives here.
package ex_muldiv_unit_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_MUL_BITS = 2;
    localparam int MUL_CYCLES   = DEF_XLEN / DEF_MUL_BITS;
    localparam int DIV_CYCLES   = DEF_XLEN;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Two ops may share a cached result only when they interpret the operands identically.
    typedef enum logic [2:0] {
        CLS_MUL_SS = 3'd0,
        CLS_MUL_SU = 3'd1,
        CLS_MUL_UU = 3'd2,
        CLS_DIV_S  = 3'd3,
        CLS_DIV_U  = 3'd4
    } sign_class_t;

    function automatic sign_class_t sign_class(input logic [2:0] funct3);
        case (funct3)
            OP_MUL, OP_MULH: return CLS_MUL_SS;
            OP_MULHSU:       return CLS_MUL_SU;
            OP_MULHU:        return CLS_MUL_UU;
            OP_DIV, OP_REM:  return CLS_DIV_S;
            default:         return CLS_DIV_U;
        endcase
    endfunction

    function automatic logic a_is_signed(input sign_class_t cls);
        return (cls == CLS_MUL_SS) || (cls == CLS_MUL_SU) || (cls == CLS_DIV_S);
    endfunction

    function automatic logic b_is_signed(input sign_class_t cls);
        return (cls == CLS_MUL_SS) || (cls == CLS_DIV_S);
    endfunction

    // MUL, DIV and DIVU return the low half of {hi, lo}; the rest return the high half.
    function automatic logic is_lo_op(input logic [2:0] funct3);
        return (funct3 == OP_MUL) || (funct3 == OP_DIV) || (funct3 == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Keep the difference when it is non-negative, otherwise restore the shifted remainder.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide with a last-result reuse cache and special-case shortcuts.
// Latency: MUL XLEN/MUL_BITS+1, DIV XLEN+1, reuse hit / divide-by-zero / overflow 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until resp_ready.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 6,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int N_MUL_STEPS = XLEN / MUL_BITS;
    localparam int N_DIV_STEPS = XLEN;
    localparam int CNT_W       = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    muldiv_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    muldiv_op_t        op_q;
    sign_class_t       cls_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_res_q, neg_rem_q;
    logic [XLEN-1:0]   opd_q;       // multiplicand for MUL, divisor for DIV
    logic [2*XLEN-1:0] acc_q;       // {hi, multiplier} for MUL, {remainder, quotient} for DIV
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;

    logic              cache_vld;
    logic [XLEN-1:0]   cache_a, cache_b, cache_hi, cache_lo;
    sign_class_t       cache_cls;

    logic              accept, last_step;
    sign_class_t       cls_in;
    logic              a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic              hit, div_zero, div_ovf, shortcut;
    logic [XLEN-1:0]   short_res;

    logic [MUL_BITS-1:0]      digit;
    logic [XLEN+MUL_BITS-1:0] psum;
    logic [2*XLEN-1:0]        mul_nxt;
    logic [XLEN-1:0]          rem_nxt, quo_nxt;
    logic [2*XLEN-1:0]        fin;

    // Decode the incoming request: magnitudes, sign flags and the one-cycle shortcut paths.
    always_comb begin
        cls_in   = sign_class(req_funct3);
        a_neg_in = a_is_signed(cls_in) & req_a[XLEN-1];
        b_neg_in = b_is_signed(cls_in) & req_b[XLEN-1];
        a_mag_in = a_neg_in ? -req_a : req_a;
        b_mag_in = b_neg_in ? -req_b : req_b;
        hit      = REUSE_EN && cache_vld && (req_a == cache_a) && (req_b == cache_b)
                   && (cls_in == cache_cls);
        div_zero = req_funct3[2] && (req_b == '0);
        div_ovf  = (cls_in == CLS_DIV_S) && (req_a == MIN_NEG) && (req_b == ALL_ONES);
        shortcut = hit | div_zero | div_ovf;
        short_res = '0;
        if (hit) begin
            short_res = is_lo_op(req_funct3) ? cache_lo : cache_hi;
        end else if (div_zero) begin
            short_res = is_lo_op(req_funct3) ? ALL_ONES : req_a;
        end else if (div_ovf) begin
            short_res = is_lo_op(req_funct3) ? req_a : '0;
        end
    end

    // One shift-add multiply step retiring MUL_BITS multiplier bits.
    always_comb begin
        digit   = acc_q[MUL_BITS-1:0];
        psum    = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                  + ({{MUL_BITS{1'b0}}, opd_q} * {{XLEN{1'b0}}, digit});
        mul_nxt = {psum, acc_q[XLEN-1:MUL_BITS]};
    end

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_q[2*XLEN-1:XLEN]),
        .quo_in  (acc_q[XLEN-1:0]),
        .divisor (opd_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // Signed fix-up folded into the final iteration so completion costs no extra cycle.
    always_comb begin
        if (state == ST_DIV) begin
            fin = {(neg_rem_q ? -rem_nxt : rem_nxt), (neg_res_q ? -quo_nxt : quo_nxt)};
        end else begin
            fin = neg_res_q ? -mul_nxt : mul_nxt;
        end
    end

    // Next-state and handshake outputs; flush overrides everything, including accept.
    always_comb begin
        state_nxt  = state;
        req_ready  = (state == ST_IDLE) & ~flush;
        accept     = req_valid & req_ready;
        resp_valid = (state == ST_DONE);
        busy       = (state != ST_IDLE);
        last_step  = (cnt == CNT_W'(1));
        case (state)
            ST_IDLE: if (accept) state_nxt = shortcut ? ST_DONE : (req_funct3[2] ? ST_DIV : ST_MUL);
            ST_MUL,
            ST_DIV:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Operand capture, iteration datapath, result/tag hold and reuse-cache update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cache_vld <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            op_q      <= muldiv_op_t'(req_funct3);
            cls_q     <= cls_in;
            tag_q     <= req_tag;
            a_q       <= req_a;
            b_q       <= req_b;
            neg_res_q <= a_neg_in ^ b_neg_in;
            neg_rem_q <= a_neg_in;
            cnt       <= req_funct3[2] ? CNT_W'(N_DIV_STEPS) : CNT_W'(N_MUL_STEPS);
            if (shortcut) result_q <= short_res;
            if (req_funct3[2]) begin
                opd_q <= b_mag_in;
                acc_q <= {{XLEN{1'b0}}, a_mag_in};
            end else begin
                opd_q <= a_mag_in;
                acc_q <= {{XLEN{1'b0}}, b_mag_in};
            end
        end else if (((state == ST_MUL) || (state == ST_DIV)) && !flush) begin
            acc_q <= (state == ST_DIV) ? {rem_nxt, quo_nxt} : mul_nxt;
            cnt   <= cnt - CNT_W'(1);
            if (last_step) begin
                result_q  <= is_lo_op(op_q) ? fin[XLEN-1:0] : fin[2*XLEN-1:XLEN];
                cache_vld <= 1'b1;
                cache_a   <= a_q;
                cache_b   <= b_q;
                cache_cls <= cls_q;
                cache_hi  <= fin[2*XLEN-1:XLEN];
                cache_lo  <= fin[XLEN-1:0];
            end
        end
    end

    assign resp_result = result_q;
    assign resp_tag    = tag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases, flush, reset, random pairs.
// Latency: measured in edges from (and including) the accept edge.
// Backpressure: resp_ready driven by the bench, optionally held low to test result hold.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]  req_funct3;
    logic [31:0] req_a, req_b, resp_result;
    logic [5:0]  req_tag, resp_tag;

    int errors = 0;
    int checks = 0;
    logic [37:0] sb_q[$];          // {tag, expected result}

    bit          tc_vld;           // bench-side view of the reuse cache
    logic [31:0] tc_a, tc_b;
    int          tc_cls;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int cls_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 0;
            3'd2:       return 1;
            3'd3:       return 2;
            3'd4, 3'd6: return 3;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && b == 32'd0)
            || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic bit is_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return tc_vld && tc_a == a && tc_b == b && tc_cls == cls_of(f3);
    endfunction

    function automatic int pred_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (is_hit(f3, a, b) || is_special(f3, a, b)) return 1;
        return f3[2] ? 33 : 17;
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        bit ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [2:0] partner(input logic [2:0] f3);
        case (f3)
            3'd0: return 3'd1;
            3'd1: return 3'd0;
            3'd4: return 3'd6;
            3'd6: return 3'd4;
            3'd5: return 3'd7;
            3'd7: return 3'd5;
            default: return f3;
        endcase
    endfunction

    // Issue one request, measure latency, optionally stall the response, then retire it.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int lat;
        bit seen;
        logic [37:0] ent;
        @(negedge clk);
        chk({name, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b; req_tag = t;
        sb_q.push_back({t, exp_res});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
            sb_q.delete();
            return;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            chk({name, "_hold_vld"}, 32'(resp_valid), 32'd1);
            chk({name, "_hold_res"}, resp_result, sb_q[0][31:0]);
            chk({name, "_hold_tag"}, 32'(resp_tag), 32'(sb_q[0][37:32]));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        ent = sb_q.pop_front();
        chk({name, "_res"}, resp_result, ent[31:0]);
        chk({name, "_tag"}, 32'(resp_tag), 32'(ent[37:32]));
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_idle_vld"}, 32'(resp_valid), 32'd0);
        if (!is_hit(f3, a, b) && !is_special(f3, a, b)) begin
            tc_vld = 1'b1; tc_a = a; tc_b = b; tc_cls = cls_of(f3);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3, pf3;
        logic [31:0] a, b;
        bit          stray;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = 3'd0; req_a = 32'd0; req_b = 32'd0; req_tag = 6'd0;
        tc_vld = 1'b0; tc_a = 32'd0; tc_b = 32'd0; tc_cls = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", resp_result, 32'd0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        rst = 1'b0;

        run_op("t1_mul",   3'd0, 32'd7, 32'hFFFF_FFFD, 6'd1, 32'hFFFF_FFEB, 17, 0);
        run_op("t1_mulh",  3'd1, 32'd7, 32'hFFFF_FFFD, 6'd2, 32'hFFFF_FFFF, 1, 0);
        run_op("t2_div",   3'd4, 32'hFFFF_FFEC, 32'd6, 6'd3, 32'hFFFF_FFFD, 33, 0);
        run_op("t2_rem",   3'd6, 32'hFFFF_FFEC, 32'd6, 6'd4, 32'hFFFF_FFFE, 1, 0);
        run_op("t3_divu",  3'd5, 32'd5, 32'd0, 6'd5, 32'hFFFF_FFFF, 1, 0);
        run_op("t3_remu",  3'd7, 32'd5, 32'd0, 6'd6, 32'd5, 1, 0);
        run_op("t4_div",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 32'h8000_0000, 1, 0);
        run_op("t4_rem",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 32'd0, 1, 0);
        run_op("t5_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9, 32'hFFFF_FFFE, 17, 5);

        // Flush a DIV in its tenth cycle while a new request is offered.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'd100; req_b = 32'd7; req_tag = 6'd10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        req_valid = 1'b1; req_funct3 = 3'd0; req_a = 32'd3; req_b = 32'd4; req_tag = 6'd11;
        #1 chk("t6_rdy_flush", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_after", 32'(busy), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || busy) stray = 1'b1;
        end
        chk("t6_no_activity", 32'(stray), 32'd0);
        run_op("t6_mul", 3'd0, 32'd3, 32'd4, 6'd12, 32'd12, 17, 0);

        // Reset in the middle of a multiply abandons it and empties the reuse cache.
        run_op("r_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 6'd13, 32'hFFFF_FFEB, 17, 0);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 6'd14;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tc_vld = 1'b0;
        @(negedge clk);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_vld", 32'(resp_valid), 32'd0);
        chk("r_res", resp_result, 32'd0);
        run_op("r_mulh", 3'd1, 32'd7, 32'hFFFF_FFFD, 6'd15, 32'hFFFF_FFFF, 17, 0);

        // Random ops, each followed by its same-class partner to exercise reuse.
        for (int i = 0; i < 6; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 2 == 1) ? $urandom_range(1, 100) : $urandom;
            if (i == 4) b = 32'd0;
            run_op("rnd", f3, a, b, 6'(20 + 2 * i), model_res(f3, a, b), pred_lat(f3, a, b), i % 3);
            pf3 = partner(f3);
            run_op("rnd_pair", pf3, a, b, 6'(21 + 2 * i), model_res(pf3, a, b), pred_lat(pf3, a, b), 0);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
